// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 raster timing shared by the display blocks
package vga_pkg;
  localparam int WIDTH = 11;
  localparam int H_VISIBLE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  function automatic logic in_window(input int unsigned v, input int unsigned lo, input int unsigned len);
    return v >= lo && v < lo + len;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster position, syncs and blanking from the timing generator
interface vga_timing_gen_if #(
  parameter int WIDTH = vga_pkg::WIDTH
);
  logic pix_en;
  logic [WIDTH-1:0] col;
  logic [WIDTH-1:0] row;
  logic HS_n;
  logic VS_n;
  logic blank;
  logic frame_start;
  modport master (output pix_en, col, row, HS_n, VS_n, blank, frame_start);
  modport slave (input pix_en, col, row, HS_n, VS_n, blank, frame_start);
endinterface

// File: rtl/vga_timing_gen_mod_counter.sv
// mod_counter: modulo-N counter with enable and a wrap flag on the terminal count
module mod_counter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         wrap
);
  assign wrap = enable && count == W'(N - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (enable) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (col/row, syncs, blank) with an internal pixel-rate enable
module vga_timing_gen #(
  parameter int CLK_DIV = 2,
  parameter int WIDTH = vga_pkg::WIDTH,
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP
) (
  input logic clk,
  input logic reset,
  vga_timing_gen_if.master vga
);
  import vga_pkg::*;
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_TOTAL - 1 >= 2 ** WIDTH || V_TOTAL - 1 >= 2 ** WIDTH) begin : g_bad_width
    $error("vga_timing_gen: WIDTH cannot hold the line/frame totals");
  end
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] col;
  logic [WIDTH-1:0] row;
  logic pix_en;
  logic col_wrap;
  logic row_wrap;
  logic unused_state;
  // Divider is enabled only out of reset so pix_en stays low while reset is held, even with CLK_DIV==1
  mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
    .clk(clk), .reset(reset), .enable(!reset), .count(div), .wrap(pix_en)
  );
  mod_counter #(.N(H_TOTAL), .W(WIDTH)) u_col (
    .clk(clk), .reset(reset), .enable(pix_en), .count(col), .wrap(col_wrap)
  );
  mod_counter #(.N(V_TOTAL), .W(WIDTH)) u_row (
    .clk(clk), .reset(reset), .enable(col_wrap), .count(row), .wrap(row_wrap)
  );
  assign unused_state = ^{row_wrap, div};
  assign vga.pix_en = pix_en;
  assign vga.col = col;
  assign vga.row = row;
  assign vga.HS_n = !in_window(32'(col), H_VISIBLE + H_FP, H_SYNC);
  assign vga.VS_n = !in_window(32'(row), V_VISIBLE + V_FP, V_SYNC);
  assign vga.blank = !(in_window(32'(col), 0, H_VISIBLE) && in_window(32'(row), 0, V_VISIBLE));
  assign vga.frame_start = pix_en && col == '0 && row == '0;
endmodule
